spi_slave_regbank: RTL
======================

Name: spi_slave_regbank

Overview:
- Parametrised SPI slave with an internal register bank, oversampled by the system clock `clock`.
- Supports all four SPI modes (CPOL/CPHA), configurable address/data widths and register count, and multi-word burst transfers.
- Frame format: command byte, then ADDR_W-bit address, then one or more DATA_W-bit data words.
- Sits between an external SPI master pin interface and on-chip control logic, which consumes the register outputs and write strobes.

Parameters:
- DATA_W, 8, data word width in bits (8..32).
- ADDR_W, 8, address field width in bits (4..16).
- NUM_REGS, 4, number of register-bank entries (1..2^ADDR_W-BASE_ADDR).
- BASE_ADDR, 8'h10, address of entry 0; entry i sits at BASE_ADDR+i.
- DEV_ID, 7'h55, device id matched against command bits [6:0].
- CPOL, 0, idle level of sclk.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- clock  input  1  system clock, at least 8x sclk frequency.
- n_reset  input  1  reset, asynchronous, active-low.
- ss  input  1  slave select, active-low, asynchronous to clock.
- sclk  input  1  SPI clock, asynchronous to clock.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data.
- miso_oe  output  1  output enable for the miso pad driver.
- reg_q  output  NUM_REGS*DATA_W  flat register contents; entry i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  output  1  one-clock pulse per committed write.
- wr_index  output  clog2(NUM_REGS) (min 1)  entry written, valid with wr_strobe.

Behaviour:
- Reset and clocking: n_reset is asynchronous, active-low; all flops are on posedge clock.
- Synchronisers: ss, sclk and mosi each pass through 2-flop synchronisers.
  - ss synchroniser resets to 0, so a frame already in progress at reset release is ignored until ss rises and falls again.
  - sclk synchroniser resets to CPOL.
- Edge detection on synchronised signals:
  - leading edge = sclk leaving CPOL; trailing edge = sclk returning to CPOL.
  - sample_edge = leading if CPHA=0, else trailing; shift_edge = the other edge.
- Output reset values: all outputs 0 (miso, miso_oe, reg_q, wr_strobe, wr_index).
- Bit order: MSB first for every field. A bit counter counts sample edges; it clears on every state change and at each word boundary.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE, DONE.
  - IDLE -> CMD on ss falling edge.
  - CMD -> after 8 samples. If cmd[6:0]==DEV_ID: go to ADDR, latching rw=cmd[7] (1 = read). Otherwise go to IGNORE.
  - ADDR -> after ADDR_W samples, go to WDATA (rw=0) or RDATA (rw=1); latch the address pointer.
  - WDATA: on each DATA_W-th sample the word completes. If pointer is in [BASE_ADDR, BASE_ADDR+NUM_REGS-1], write the entry and pulse wr_strobe the next clock with wr_index. Out-of-range writes are dropped with no strobe. Pointer then advances.
  - RDATA: the read word is loaded in the clock after the final address sample, and after each completed word. Out-of-range reads return all-zero. miso shifts the next bit on every shift_edge while in RDATA; the first shift_edge in RDATA drives the MSB. Pointer advances per completed word.
  - IGNORE: miso_oe stays 0; nothing is written.
  - Any non-IDLE state -> DONE on ss rising edge. DONE holds 2 clocks, then returns to IDLE.
- miso_oe is 1 only in RDATA. miso returns to 0 in IDLE.
- Partial words at ss rise are discarded.
- If a word completes in the same clock ss rise is detected, the write commits.
- Pointer arithmetic is modulo 2^ADDR_W (wrap-around).
- An ss rise during CMD or ADDR produces no writes.

Optional Feature:
- Macro: SPI_REGBANK_AUTOINC_EN.
- Defined: the address pointer increments by 1 after every completed data word, enabling bursts.
- Undefined: the pointer holds; each burst word targets the same address (FIFO-style repeated access).

Decomposition:
- Package spi_regbank_pkg holds:
  - state enum and encoding (IDLE=0 .. DONE=6);
  - command bit positions (RW_BIT=7, ID field [6:0]);
  - the clog2 helper function.
- One natural sub-module, spi_edge_sync: 2-flop synchroniser plus rise/fall detection, parametrised by reset value, instantiated for ss, sclk and mosi.

Test Plan (DATA_W=8, ADDR_W=8, BASE_ADDR=8'h10, NUM_REGS=4, DEV_ID=7'h55, sclk = clock/16):
- Mode 0 single write: cmd 0x55, addr 0x12, data 0xA5 -> reg_q[23:16]=0xA5; one wr_strobe with wr_index=2; other entries 0.
- Mode 0 read-back: cmd 0xD5, addr 0x12 -> miso shifts 0xA5 MSB-first, miso_oe high only during the data byte.
- Mode 3 burst write, AUTOINC_EN defined: addr 0x13, data 0x11, 0x22 -> entry 3=0x11; address 0x14 out of range, so the second word is dropped; exactly one strobe. With AUTOINC_EN undefined: entry 3=0x22, two strobes.
- Wrong id: cmd 0x54, addr 0x10, data 0xFF -> no strobe, reg_q unchanged, miso_oe stays 0 for the whole frame.
- Abort: ss rises after 5 data bits of a write to 0x10 -> no strobe. A following full write of 0x3C to 0x10 succeeds.
- Reset mid-frame: n_reset pulsed low while ss low in WDATA -> all outputs 0. The rest of that frame is ignored; the next ss falling edge starts a normal frame.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// Shared FSM encoding, command-byte layout and sizing helpers for spi_slave_regbank.
package spi_regbank_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WDATA  = 3'd3,
      ST_RDATA  = 3'd4,
      ST_IGNORE = 3'd5,
      ST_DONE   = 3'd6
   } state_e;

   localparam int CMD_W  = 8;
   localparam int RW_BIT = 7;
   localparam int ID_MSB = 6;

   function automatic int clog2(input int unsigned v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin, with one-clock rise/fall pulses
// derived from the synchronised level. RST_VAL sets the level assumed during reset.
module spi_edge_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock,
   input  logic n_reset,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;
   assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_regbank.sv
// Oversampled SPI slave fronting a small register bank (command, address, data words).
// Build macro SPI_REGBANK_AUTOINC_EN: pointer steps by one per completed data word.
module spi_slave_regbank
   import spi_regbank_pkg::*;
#(
   parameter int          DATA_W    = 8,
   parameter int          ADDR_W    = 8,
   parameter int          NUM_REGS  = 4,
   parameter int unsigned BASE_ADDR = 'h10,
   parameter logic [6:0]  DEV_ID    = 7'h55,
   parameter logic        CPOL      = 1'b0,
   parameter logic        CPHA      = 1'b0,
   localparam int         IDX_W     = (clog2(NUM_REGS) > 0) ? clog2(NUM_REGS) : 1
) (
   input  logic                       clock,
   input  logic                       n_reset,
   input  logic                       ss,
   input  logic                       sclk,
   input  logic                       mosi,
   output logic                       miso,
   output logic                       miso_oe,
   output logic [NUM_REGS*DATA_W-1:0] reg_q,
   output logic                       wr_strobe,
   output logic [IDX_W-1:0]           wr_index
);

   localparam int SH_W  = max3(CMD_W, ADDR_W, DATA_W);
   localparam int CNT_W = clog2(SH_W) + 1;
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
`ifdef SPI_REGBANK_AUTOINC_EN
   localparam logic [ADDR_W-1:0] PTR_STEP = ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] PTR_STEP = '0;
`endif

   logic ss_lvl, ss_rise, ss_fall;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic unused_sync;

   // ss resets low so a frame already running at reset release is not joined.
   spi_edge_sync #(.RST_VAL(1'b0)) u_ss_sync (
      .clock(clock), .n_reset(n_reset), .async_i(ss),
      .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall));

   spi_edge_sync #(.RST_VAL(CPOL)) u_sclk_sync (
      .clock(clock), .n_reset(n_reset), .async_i(sclk),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));

   spi_edge_sync #(.RST_VAL(1'b0)) u_mosi_sync (
      .clock(clock), .n_reset(n_reset), .async_i(mosi),
      .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

   assign unused_sync = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

   logic lead_e, trail_e, sample_e, shift_e;
   assign lead_e   = CPOL ? sclk_fall : sclk_rise;
   assign trail_e  = CPOL ? sclk_rise : sclk_fall;
   assign sample_e = CPHA ? trail_e : lead_e;
   assign shift_e  = CPHA ? lead_e : trail_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SH_W-1:0]     sh_q, sh_d, sh_next;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                load_q, load_d;
   logic [DATA_W-1:0]   rd_sh_q, rd_sh_d;
   logic                miso_q, miso_d;
   logic                wr_strobe_q, wr_strobe_d;
   logic [IDX_W-1:0]    wr_index_q, wr_index_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   logic [ADDR_W-1:0]   off;
   logic                in_range;
   logic [IDX_W-1:0]    idx;
   logic [DATA_W-1:0]   rd_word;
   logic                wr_en;

   // Pointer offset from the bank base; below-base pointers wrap to a large offset.
   assign off      = ptr_q - BASE_A;
   assign in_range = ({1'b0, off} < (ADDR_W+1)'(NUM_REGS));
   assign idx      = off[IDX_W-1:0];
   assign rd_word  = in_range ? regs_q[idx] : '0;
   assign sh_next  = {sh_q[SH_W-2:0], mosi_lvl};

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         sh_q        <= '0;
         rw_q        <= 1'b0;
         ptr_q       <= '0;
         load_q      <= 1'b0;
         rd_sh_q     <= '0;
         miso_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_index_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         rw_q        <= rw_d;
         ptr_q       <= ptr_d;
         load_q      <= load_d;
         rd_sh_q     <= rd_sh_d;
         miso_q      <= miso_d;
         wr_strobe_q <= wr_strobe_d;
         wr_index_q  <= wr_index_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      rw_d        = rw_q;
      ptr_d       = ptr_q;
      load_d      = 1'b0;
      rd_sh_d     = rd_sh_q;
      miso_d      = miso_q;
      wr_strobe_d = 1'b0;
      wr_index_d  = wr_index_q;
      wr_en       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            miso_d = 1'b0;
            if (ss_fall) state_d = ST_CMD;
         end
         ST_CMD: begin
            if (sample_e) begin
               sh_d = sh_next;
               if (cnt_q == CNT_W'(CMD_W-1)) begin
                  cnt_d = '0;
                  if (sh_next[ID_MSB:0] == DEV_ID) begin
                     rw_d    = sh_next[RW_BIT];
                     state_d = ST_ADDR;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_ADDR: begin
            if (sample_e) begin
               sh_d = sh_next;
               if (cnt_q == CNT_W'(ADDR_W-1)) begin
                  cnt_d   = '0;
                  ptr_d   = sh_next[ADDR_W-1:0];
                  state_d = rw_q ? ST_RDATA : ST_WDATA;
                  load_d  = rw_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_WDATA: begin
            if (sample_e) begin
               sh_d = sh_next;
               if (cnt_q == CNT_W'(DATA_W-1)) begin
                  cnt_d = '0;
                  ptr_d = ptr_q + PTR_STEP;
                  if (in_range) begin
                     wr_en       = 1'b1;
                     wr_strobe_d = 1'b1;
                     wr_index_d  = idx;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_RDATA: begin
            if (shift_e) begin
               miso_d  = rd_sh_q[DATA_W-1];
               rd_sh_d = {rd_sh_q[DATA_W-2:0], 1'b0};
            end
            // The word is fetched one clock after the pointer settles.
            if (load_q) rd_sh_d = rd_word;
            if (sample_e) begin
               if (cnt_q == CNT_W'(DATA_W-1)) begin
                  cnt_d  = '0;
                  ptr_d  = ptr_q + PTR_STEP;
                  load_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_IGNORE: begin
            cnt_d = '0;
         end
         ST_DONE: begin
            miso_d = 1'b0;
            if (cnt_q == CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      // A word finishing in the same clock as ss rise still commits above.
      if (ss_rise && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
         state_d = ST_DONE;
         cnt_d   = '0;
         load_d  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[idx] <= sh_next[DATA_W-1:0];
      end
   end

   always_comb begin
      reg_q = '0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs_q[i];
   end

   assign miso      = miso_q;
   assign miso_oe   = (state_q == ST_RDATA);
   assign wr_strobe = wr_strobe_q;
   assign wr_index  = wr_index_q;

endmodule
